// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM state type
// and the default DataMEM size.
package mem_pkg;

  localparam int MEM_BYTES_DEFAULT = 64;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Load lane extraction from a big-endian memory word, followed by sign or zero
// extension of sub-word results. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    // Big-endian: the lowest byte address sits in the top byte of the word.
    case (lane_i)
      2'd0:    byte_sel = word_i[31:24];
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = lane_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    data_o = word_i;
    case (size_i)
      SZ_BYTE: data_o = sign_i ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
      SZ_HALF: data_o = sign_i ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store front-end for a word-wide big-endian DataMEM: alignment and
// range checks, sub-word read-modify-write, and load lane extraction.
//
// state    | meaning
// ST_IDLE  | ready for a request, memory outputs hold their last value
// ST_READ  | aligned word on mem_addr, mem_rdata captured at cycle end
// ST_WRITE | mem_rw high with mem_addr/mem_wdata stable for the cycle
// ST_RESP  | resp_valid high for exactly one cycle
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rw_q, mem_rw_d;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;

  function automatic logic [31:0] rmw_merge(input logic [31:0] old_word,
                                            input logic [15:0] wd,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    w[31:24] = wd[7:0];
        2'd1:    w[23:16] = wd[7:0];
        2'd2:    w[15:8]  = wd[7:0];
        default: w[7:0]   = wd[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (lane[1]) w[15:0] = wd;
      else         w[31:16] = wd;
    end
    return w;
  endfunction

  assign accept  = req_valid && req_ready_q;
  assign req_err = (req_size == SZ_ILLEGAL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || (req_addr > 32'(MEM_BYTES - 1));

  mem_lane_align u_lane_align (
    .word_i (mem_rdata),
    .lane_i (lane_q),
    .size_i (size_q),
    .sign_i (signed_q),
    .data_o (load_data)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rw_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d        = req_we;
          size_d      = req_size;
          signed_d    = req_signed;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata[15:0];
          req_ready_d = 1'b0;
          if (req_err) begin
            // Errors never touch the memory port; mem_addr keeps its old value.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_we && (req_size == SZ_WORD)) begin
              state_d     = ST_WRITE;
              mem_wdata_d = req_wdata;
              mem_rw_d    = 1'b1;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end

      ST_READ: begin
        if (we_q) begin
          state_d     = ST_WRITE;
          mem_wdata_d = rmw_merge(mem_rdata, wdata_q, size_q, lane_q);
          mem_rw_d    = 1'b1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end

      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_rw_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rw_q     <= mem_rw_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rw     = mem_rw_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: DataMEM model plus a byte-array reference of
// memory contents, directed cases followed by random loads/stores.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int MEM_BYTES = 64;
  localparam int WORDS     = MEM_BYTES / 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw;

  logic [31:0] dmem [WORDS];
  logic [7:0]  ref_mem [MEM_BYTES];
  int          checks = 0;
  int          failures = 0;
  int          write_count = 0;
  logic [31:0] last_waddr = 32'h0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[5:2]];

  always @(posedge CLK) begin
    if (mem_rw) begin
      dmem[mem_addr[5:2]] <= mem_wdata;
      write_count         <= write_count + 1;
      last_waddr          <= mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  task automatic check_all_mem(input string tag);
    for (int i = 0; i < WORDS; i++) check(tag, dmem[i], ref_word(4 * i));
  endtask

  // One complete request; expected behaviour derived from the byte-level model.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    int nbytes, exp_lat, exp_writes, lat, w0, base;
    logic exp_err;
    logic [31:0] v;
    nbytes  = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    exp_err = (sz == SZ_ILLEGAL) || ((addr % 32'(nbytes)) != 32'd0)
           || (addr >= 32'(MEM_BYTES));
    v = 32'h0;
    if (!exp_err) begin
      base = int'(addr);
      for (int i = 0; i < nbytes; i++) v = (v << 8) | 32'(ref_mem[base + i]);
      if (sg && nbytes < 4 && v[8*nbytes-1])
        v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
      if (we) begin
        for (int i = 0; i < nbytes; i++)
          ref_mem[base + i] = 8'(wd >> (8 * (nbytes - 1 - i)));
        v = 32'h0;
      end
    end
    exp_lat    = exp_err ? 1 : ((!we || nbytes == 4) ? 2 : 3);
    exp_writes = (exp_err || !we) ? 0 : 1;

    @(negedge CLK);
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    w0 = write_count;
    @(posedge CLK); #1;
    // Junk while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
    req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    req_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, v);
    rd = resp_rdata;
    @(posedge CLK); #1;
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    check("write_cycles", 32'(write_count - w0), 32'(exp_writes));
    if (exp_writes == 1) check("write_addr", last_waddr, addr & ~32'd3);
    if (addr < 32'(MEM_BYTES))
      check("mem_word", dmem[addr[5:2]], ref_word(int'(addr & ~32'd3)));
  endtask

  initial begin
    logic [31:0] rd, v;
    int w0;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      dmem[i] <= v;
      ref_mem[4*i]   = v[31:24];
      ref_mem[4*i+1] = v[23:16];
      ref_mem[4*i+2] = v[15:8];
      ref_mem[4*i+3] = v[7:0];
    end

    // Reset held with a pending request
    repeat (3) begin
      @(negedge CLK);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd0);
    end
    Reset = 1'b0; req_valid = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("rst_no_write", 32'(write_count), 32'd0);

    // Directed word / byte / half traffic on word 0x08
    do_req(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h11223344, rd);
    check("spec_word_mem", dmem[2], 32'h11223344);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, rd);
    check("spec_load_word", rd, 32'h11223344);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h09, 32'hFFFFFFAB, rd);
    check("spec_byte_mem", dmem[2], 32'h11AB3344);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0, rd);
    check("spec_lb_signed", rd, 32'hFFFFFFAB);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0, rd);
    check("spec_lb_unsigned", rd, 32'h000000AB);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h0A, 32'h1234BEEF, rd);
    check("spec_half_mem", dmem[2], 32'h11ABBEEF);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0, rd);
    check("spec_lh_signed", rd, 32'hFFFFBEEF);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h08, 32'h0, rd);
    check("spec_lh_unsigned", rd, 32'h000011AB);

    // Error cases, both as stores and loads
    do_req(1'b1, SZ_HALF, 1'b0, 32'h0B, 32'hCAFE, rd);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0A, 32'hCAFEF00D, rd);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h40, 32'h77, rd);
    do_req(1'b1, SZ_ILLEGAL, 1'b0, 32'h08, 32'h99, rd);
    do_req(1'b0, SZ_WORD, 1'b1, 32'h0A, 32'h0, rd);
    check("err_word_unchanged", dmem[2], 32'h11ABBEEF);
    check_all_mem("err_mem_unchanged");

    // Reset while the RMW read of a byte store is in progress
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h09; req_wdata = 32'h5A;
    w0 = write_count;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("abort_read_rw", 32'(mem_rw), 32'd0);
    check("abort_read_addr", mem_addr, 32'h08);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK); #1;
    check("abort_mem_rw", 32'(mem_rw), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    @(negedge CLK);
    Reset = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    check("abort_no_write", 32'(write_count - w0), 32'd0);
    check("abort_word", dmem[2], 32'h11ABBEEF);

    // Random traffic, mostly in range
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 7));
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, rd);
    end
    check_all_mem("final_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_BYTES, default 64, SHALL be the size in bytes of the attached DataMEM.
REQ-002 CLK  input  1  SHALL be the only clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL signal that a CPU access request is present.
REQ-005 req_ready  output  1  SHALL be high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-006 req_we  input  1  SHALL select the operation: 1=store, 0=load.
REQ-007 req_size  input  2  SHALL encode the access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  input  1  SHALL select sign-extension (1) or zero-extension (0) for sub-word loads.
REQ-009 req_addr  input  32  SHALL carry the byte address.
REQ-010 req_wdata  input  32  SHALL carry store data, right-justified for sub-word stores.
REQ-011 resp_valid  output  1  SHALL pulse for one cycle per accepted request.
REQ-012 resp_rdata  output  32  SHALL carry load data; 0 for stores and errors.
REQ-013 resp_err  output  1  SHALL be valid with resp_valid and flag a misaligned, out-of-range or illegal-size request.
REQ-014 mem_addr  output  32  SHALL be a registered, word-aligned address driven to DataMEM addr.
REQ-015 mem_wdata  output  32  SHALL be registered write data driven to DataMEM i_data.
REQ-016 mem_rw  output  1  SHALL be a registered write strobe driven to DataMEM DataMemRW (1=write).
REQ-017 mem_rdata  input  32  SHALL be DataMEM o_data, combinational, big-endian (byte at mem_addr = bits 31:24).

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE and RESP.
REQ-019 On accept, the unit SHALL latch all req_* fields and compute aligned = {addr[31:2],2'b00}.
REQ-020 The request SHALL be an error if size==11, half && addr[0], word && addr[1:0]!=0, or addr > MEM_BYTES-1.
REQ-021 Transitions SHALL be: error IDLE->RESP; load IDLE->READ->RESP; word store IDLE->WRITE->RESP; sub-word store IDLE->READ->WRITE->RESP; RESP->IDLE.
REQ-022 Latency from the accept edge to resp_valid high SHALL be: error 1 cycle; load and word store 2 cycles; sub-word store 3 cycles.
REQ-023 In READ, mem_addr SHALL equal the aligned address, mem_rw SHALL be 0, and mem_rdata SHALL be captured at the end of the cycle.
REQ-024 mem_rw SHALL be 1 only in WRITE, with mem_addr and mem_wdata both valid for that entire cycle.
REQ-025 mem_addr SHALL stay unchanged on the edge leaving WRITE and SHALL hold its last value while idle.
REQ-026 Load lane extraction: byte lane L=addr[1:0] SHALL come from bits [31-8L -: 8]; half lane SHALL come from [31:16] if addr[1]==0, else [15:0]; the result SHALL then be sign- or zero-extended per req_signed.
REQ-027 Sub-word store SHALL read-modify-write, replacing only the addressed byte lane with wdata[7:0] or the addressed half lane with wdata[15:0].
REQ-028 An erroring request SHALL never assert mem_rw and SHALL report resp_rdata=0.
REQ-029 req_valid SHALL be ignored outside IDLE; a new request SHALL be acceptable on the cycle after RESP.

Reset
REQ-030 Reset SHALL force: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_rw=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no response, and SHALL prevent any write from occurring after the reset edge.
REQ-032 Reset SHALL take priority over req_valid on the same edge.

Structure
REQ-033 Package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and MEM_BYTES_DEFAULT.
REQ-034 Combinational load alignment and extension SHALL reside in sub-module mem_lane_align; the FSM and RMW merge SHALL remain in mem_access_unit.

Verification
REQ-035 Reset held with req_valid=1 -> all outputs at reset values; no accept until Reset is low; req_ready=1 afterwards.
REQ-036 Store word 0x11223344 @0x08 -> resp 2 cycles after accept, one WRITE cycle with mem_addr=0x08; load word @0x08 -> 0x11223344.
REQ-037 Store byte 0xAB @0x09 -> READ then WRITE, memory word 0x11AB3344; load byte signed @0x09 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-038 Store half 0xBEEF @0x0A -> word 0x11ABBEEF; load half signed @0x0A -> 0xFFFFBEEF; unsigned @0x08 -> 0x000011AB.
REQ-039 Half @0x0B, word @0x0A, byte @0x40, size 11 -> each gives resp_err=1 one cycle after accept, mem_rw never 1, memory unchanged.
REQ-040 Reset during READ of byte store @0x09 -> no WRITE occurs, word @0x08 unchanged, resp_valid stays 0.
